// File: rtl/vox_pkg.sv
// Shared encodings for the SPI transmit arbiter: owner codes, FSM states
// and the default starvation and lock-timeout limits.
package vox_pkg;

    localparam int BYTE_W           = 8;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int LOCK_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_AUDIO = 2'd1,
        OWNER_CFG   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/spi_req_slot.sv
// One-byte request slot: holds a requester's byte until the arbiter retires
// it, and flags any start that arrives while the slot is still occupied.
module spi_req_slot
    import vox_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_clear,
    output logic              o_pending,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_overrun
);

    logic              r_pending;
    logic [BYTE_W-1:0] r_data;
    logic              r_overrun;
    logic              w_accept;

    // A start landing on the same edge the held byte retires is a reload.
    assign w_accept = i_start && (!r_pending || i_clear);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= 1'b1;
                r_data    <= i_data;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
            if (i_start && !w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/spi_tx_arbiter.sv
// Arbitrates an audio and a config byte requester onto one SPI byte engine,
// with frame locks, config anti-starvation and a lock watchdog.
module spi_tx_arbiter
    import vox_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_tx_start,
    input  logic [7:0] a_tx_data,
    input  logic       a_lock,
    output logic       a_tx_busy,
    input  logic       b_tx_start,
    input  logic [7:0] b_tx_data,
    input  logic       b_lock,
    output logic       b_tx_busy,
    output logic       spi_tx_start,
    output logic [7:0] spi_tx_data,
    input  logic       spi_tx_busy,
    output logic [1:0] owner,
    output logic       a_overrun,
    output logic       b_overrun,
    output logic       lock_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TIMEOUT - 1);

    arb_state_t  r_state;
    owner_t      r_owner;
    logic        r_spiStart;
    logic [7:0]  r_spiData;
    logic        r_lockErr;
    logic [SW-1:0] r_starveCnt;
    logic [LW-1:0] r_lockCnt;
    logic        r_aLockIgn;
    logic        r_bLockIgn;

    logic        w_aPending, w_bPending;
    logic [7:0]  w_aData, w_bData;
    logic        w_aOverrun, w_bOverrun;
    logic        w_byteDone, w_aClear, w_bClear;
    logic        w_aLockEff, w_bLockEff;
    logic        w_aElig, w_bElig, w_pickCfg, w_grant;
    logic        w_ownerLocked, w_ownerPending, w_lockCount, w_timeout;

    spi_req_slot u_aSlot (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (a_tx_start),
        .i_data    (a_tx_data),
        .i_clear   (w_aClear),
        .o_pending (w_aPending),
        .o_data    (w_aData),
        .o_overrun (w_aOverrun)
    );

    spi_req_slot u_bSlot (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (b_tx_start),
        .i_data    (b_tx_data),
        .i_clear   (w_bClear),
        .o_pending (w_bPending),
        .o_data    (w_bData),
        .o_overrun (w_bOverrun)
    );

    // The current owner is always the requester whose byte is in flight.
    assign w_byteDone = (r_state == ST_WAIT_ACK || r_state == ST_WAIT_DONE) && !spi_tx_busy;
    assign w_aClear   = w_byteDone && (r_owner == OWNER_AUDIO);
    assign w_bClear   = w_byteDone && (r_owner == OWNER_CFG);

    assign w_aLockEff = a_lock && !r_aLockIgn;
    assign w_bLockEff = b_lock && !r_bLockIgn;

    assign w_aElig   = w_aPending && !(r_owner == OWNER_CFG   && w_bLockEff);
    assign w_bElig   = w_bPending && !(r_owner == OWNER_AUDIO && w_aLockEff);
    assign w_pickCfg = w_bElig && (!w_aElig || (r_starveCnt >= STARVE_MAX));
    assign w_grant   = (r_state == ST_IDLE) && (w_aElig || w_bElig);

    assign w_ownerLocked  = (r_owner == OWNER_AUDIO && w_aLockEff) ||
                            (r_owner == OWNER_CFG   && w_bLockEff);
    assign w_ownerPending = (r_owner == OWNER_AUDIO && w_aPending) ||
                            (r_owner == OWNER_CFG   && w_bPending);
    assign w_lockCount    = (r_state == ST_IDLE) && w_ownerLocked && !w_ownerPending;
    assign w_timeout      = w_lockCount && (r_lockCnt == LOCK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWNER_NONE;
            r_spiStart <= 1'b0;
            r_spiData  <= '0;
            r_lockErr  <= 1'b0;
        end else begin
            r_spiStart <= 1'b0;
            r_spiData  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_aElig || w_bElig) begin
                        r_state    <= ST_ISSUE;
                        r_spiStart <= 1'b1;
                        if (w_pickCfg) begin
                            r_owner   <= OWNER_CFG;
                            r_spiData <= w_bData;
                        end else begin
                            r_owner   <= OWNER_AUDIO;
                            r_spiData <= w_aData;
                        end
                    end else if (w_timeout) begin
                        r_owner   <= OWNER_NONE;
                        r_lockErr <= 1'b1;
                    end else if (!w_ownerLocked) begin
                        r_owner <= OWNER_NONE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    r_state <= spi_tx_busy ? ST_WAIT_DONE : ST_IDLE;
                end
                ST_WAIT_DONE: begin
                    if (!spi_tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_bPending) begin
            r_starveCnt <= '0;
        end else if (w_grant) begin
            if (w_pickCfg) begin
                r_starveCnt <= '0;
            end else if (r_starveCnt < STARVE_MAX) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_lockCount || w_timeout) begin
            r_lockCnt <= '0;
        end else begin
            r_lockCnt <= r_lockCnt + 1'b1;
        end
    end

    // A lock released by the watchdog stays ignored until the requester drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aLockIgn <= 1'b0;
            r_bLockIgn <= 1'b0;
        end else begin
            if (!a_lock) begin
                r_aLockIgn <= 1'b0;
            end else if (w_timeout && r_owner == OWNER_AUDIO) begin
                r_aLockIgn <= 1'b1;
            end
            if (!b_lock) begin
                r_bLockIgn <= 1'b0;
            end else if (w_timeout && r_owner == OWNER_CFG) begin
                r_bLockIgn <= 1'b1;
            end
        end
    end

    assign a_tx_busy    = w_aPending;
    assign b_tx_busy    = w_bPending;
    assign spi_tx_start = r_spiStart;
    assign spi_tx_data  = r_spiData;
    assign owner        = r_owner;
    assign a_overrun    = w_aOverrun;
    assign b_overrun    = w_bOverrun;
    assign lock_err     = r_lockErr;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: an 8-cycle SPI engine model, a strobe
// monitor, and a scoreboard of expected bytes and owners per scenario.
module tb_spi_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_tx_start = 1'b0, b_tx_start = 1'b0;
    logic [7:0] a_tx_data = 8'h00, b_tx_data = 8'h00;
    logic       a_lock = 1'b0, b_lock = 1'b0;
    logic       a_tx_busy, b_tx_busy, spi_tx_start, spi_tx_busy;
    logic [7:0] spi_tx_data;
    logic [1:0] owner;
    logic       a_overrun, b_overrun, lock_err;

    int checks = 0;
    int fails = 0;
    int timeouts = 0;

    logic [7:0] expQ[$];
    logic [1:0] expOwnerQ[$];
    logic [7:0] obsQ[$];
    logic [1:0] obsOwnerQ[$];

    int dataLeak = 0, strobeRun = 0, aBusyGap = 0, ownerGap = 0;
    bit trackA = 1'b0;
    logic prevStart = 1'b0;
    int engCnt = 0;

    spi_tx_arbiter dut (
        .clk(clk), .rst(rst),
        .a_tx_start(a_tx_start), .a_tx_data(a_tx_data), .a_lock(a_lock), .a_tx_busy(a_tx_busy),
        .b_tx_start(b_tx_start), .b_tx_data(b_tx_data), .b_lock(b_lock), .b_tx_busy(b_tx_busy),
        .spi_tx_start(spi_tx_start), .spi_tx_data(spi_tx_data), .spi_tx_busy(spi_tx_busy),
        .owner(owner), .a_overrun(a_overrun), .b_overrun(b_overrun), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Engine model: busy for 8 cycles starting the cycle after each strobe; it ignores rst.
    assign spi_tx_busy = (engCnt != 0);
    always @(posedge clk) begin
        if (spi_tx_start) engCnt <= 8;
        else if (engCnt != 0) engCnt <= engCnt - 1;
    end

    // Monitor records every strobe and tallies protocol violations.
    always @(negedge clk) begin
        if (spi_tx_start === 1'b1) begin
            obsQ.push_back(spi_tx_data);
            obsOwnerQ.push_back(owner);
        end
        if (spi_tx_start === 1'b0 && spi_tx_data !== 8'h00) dataLeak++;
        if (spi_tx_start === 1'b1 && prevStart === 1'b1) strobeRun++;
        prevStart = spi_tx_start;
        if (trackA && a_tx_busy !== 1'b1) aBusyGap++;
        if (trackA && owner !== 2'd1) ownerGap++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pushExp(input logic [7:0] d, input logic [1:0] o);
        expQ.push_back(d);
        expOwnerQ.push_back(o);
    endtask

    task automatic pulseA(input logic [7:0] d);
        a_tx_start = 1'b1; a_tx_data = d;
        tick();
        a_tx_start = 1'b0; a_tx_data = 8'h00;
    endtask

    task automatic pulseB(input logic [7:0] d);
        b_tx_start = 1'b1; b_tx_data = d;
        tick();
        b_tx_start = 1'b0; b_tx_data = 8'h00;
    endtask

    task automatic waitByteDone();
        int n = 0;
        while (spi_tx_busy !== 1'b1 && n < 60) begin tick(); n++; end
        if (spi_tx_busy !== 1'b1) timeouts++;
        n = 0;
        while (spi_tx_busy === 1'b1 && n < 60) begin tick(); n++; end
        if (spi_tx_busy === 1'b1) timeouts++;
    endtask

    task automatic waitStrobes(input int n);
        int k = 0;
        while (obsQ.size() < n && k < 400) begin tick(); k++; end
        if (obsQ.size() < n) timeouts++;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        a_tx_start = 1'b0; b_tx_start = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        expQ.delete(); expOwnerQ.delete(); obsQ.delete(); obsOwnerQ.delete();
        trackA = 1'b0; aBusyGap = 0; ownerGap = 0; timeouts = 0;
    endtask

    task automatic test_reset();
        a_tx_start = 1'b1; a_tx_data = 8'hEE; b_tx_start = 1'b1; b_tx_data = 8'hDD;
        tick();
        rst = 1'b0; a_tx_start = 1'b0; b_tx_start = 1'b0;
        checks++;
        if ({spi_tx_start, spi_tx_data, owner, a_tx_busy, b_tx_busy} !== 13'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got start=%b data=%h owner=%0d abusy=%b bbusy=%b, required all 0",
                     spi_tx_start, spi_tx_data, owner, a_tx_busy, b_tx_busy);
        end
        checks++;
        if ({a_overrun, b_overrun, lock_err} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b, required 000", {a_overrun, b_overrun, lock_err});
        end
        repeat (20) tick();
        checks++;
        if (obsQ.size() != 0 || a_tx_busy !== 1'b0 || b_tx_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_start_ignored: got %0d strobes abusy=%b bbusy=%b, required 0 0 0",
                     obsQ.size(), a_tx_busy, b_tx_busy);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        applyReset();
        a_tx_start = 1'b1; a_tx_data = 8'h11; b_tx_start = 1'b1; b_tx_data = 8'h22;
        pushExp(8'h11, 2'd1); pushExp(8'h22, 2'd2);
        tick();
        a_tx_start = 1'b0; b_tx_start = 1'b0;
        waitStrobes(2);
        waitByteDone();
        repeat (3) tick();
        checks++;
        if (owner !== 2'd0) begin
            fails++;
            $display("[TB] FAIL same_owner_release: got %0d, required 0", owner);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL same_count: got %0d strobes, required %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL same_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL same_timeout: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_locked_pair();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        applyReset();
        a_lock = 1'b1;
        pulseA(8'hCA); pushExp(8'hCA, 2'd1);
        tick();
        trackA = 1'b1;
        waitByteDone();
        pulseA(8'hFE); pushExp(8'hFE, 2'd1);
        waitStrobes(2);
        trackA = 1'b0;
        waitByteDone();
        a_lock = 1'b0;
        repeat (3) tick();
        checks++;
        if (aBusyGap != 0 || ownerGap != 0) begin
            fails++;
            $display("[TB] FAIL pair_continuity: got %0d busy gaps %0d owner gaps, required 0 0", aBusyGap, ownerGap);
        end
        checks++;
        if (owner !== 2'd0 || a_tx_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pair_release: got owner=%0d abusy=%b, required 0 0", owner, a_tx_busy);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL pair_count: got %0d strobes, required %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL pair_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL pair_timeout: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_lock_no_interleave();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        applyReset();
        a_lock = 1'b1;
        pulseA(8'h01); pushExp(8'h01, 2'd1);
        tick();
        pulseB(8'h55);
        waitByteDone();
        pulseA(8'h02); pushExp(8'h02, 2'd1);
        waitByteDone();
        repeat (20) tick();
        checks++;
        if (obsQ.size() != 2 || b_tx_busy !== 1'b1 || owner !== 2'd1) begin
            fails++;
            $display("[TB] FAIL lock_hold: got %0d strobes bbusy=%b owner=%0d, required 2 1 1",
                     obsQ.size(), b_tx_busy, owner);
        end
        pushExp(8'h55, 2'd2);
        a_lock = 1'b0;
        waitStrobes(3);
        waitByteDone();
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL lock_count: got %0d strobes, required %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL lock_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL lock_timeout_wait: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_starvation();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        applyReset();
        a_tx_start = 1'b1; a_tx_data = 8'h10; b_tx_start = 1'b1; b_tx_data = 8'h5A;
        pushExp(8'h10, 2'd1);
        tick();
        a_tx_start = 1'b0; b_tx_start = 1'b0;
        // Audio reloads on every completion; config must cut in after four audio grants.
        for (int i = 0; i < 4; i++) begin
            waitByteDone();
            if (i == 3) pushExp(8'h5A, 2'd2);
            pushExp(8'h11 + 8'(i), 2'd1);
            pulseA(8'h11 + 8'(i));
        end
        waitStrobes(6);
        waitByteDone();
        checks++;
        if (a_overrun !== 1'b0 || b_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL starve_overrun: got %b%b, required 00", a_overrun, b_overrun);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            fails++;
            $display("[TB] FAIL starve_count: got %0d strobes, required %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL starve_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL starve_timeout: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        applyReset();
        pulseA(8'h3C); pushExp(8'h3C, 2'd1);
        checks++;
        if (a_overrun !== 1'b0 || a_tx_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL overrun_pre: got ovr=%b abusy=%b, required 0 1", a_overrun, a_tx_busy);
        end
        pulseA(8'h99);
        checks++;
        if (a_overrun !== 1'b1 || b_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL overrun_flag: got a=%b b=%b, required 1 0", a_overrun, b_overrun);
        end
        waitByteDone();
        repeat (20) tick();
        checks++;
        if (obsQ.size() != expQ.size() || a_tx_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL overrun_count: got %0d strobes abusy=%b, required %0d 0",
                     obsQ.size(), a_tx_busy, expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL overrun_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL overrun_timeout: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_lock_timeout_and_reset();
        logic [7:0] eb, gb;
        logic [1:0] eo, go;
        int n;
        applyReset();
        b_lock = 1'b1;
        pulseB(8'h77); pushExp(8'h77, 2'd2);
        waitByteDone();
        pulseA(8'hAB); pushExp(8'hAB, 2'd1);
        n = 0;
        repeat (1000) begin tick(); n++; end
        checks++;
        if (lock_err !== 1'b0 || owner !== 2'd2 || obsQ.size() != 1) begin
            fails++;
            $display("[TB] FAIL timeout_early: got err=%b owner=%0d strobes=%0d, required 0 2 1",
                     lock_err, owner, obsQ.size());
        end
        while (lock_err !== 1'b1 && n < 1100) begin tick(); n++; end
        checks++;
        if (n != 1024 || owner !== 2'd0) begin
            fails++;
            $display("[TB] FAIL timeout_release: got %0d idle cycles owner=%0d, required 1024 0", n, owner);
        end
        tick();
        checks++;
        if (spi_tx_start !== 1'b1 || spi_tx_data !== 8'hAB) begin
            fails++;
            $display("[TB] FAIL timeout_issue: got start=%b data=%h, required 1 ab", spi_tx_start, spi_tx_data);
        end
        repeat (3) tick();
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            eb = expQ.pop_front(); eo = expOwnerQ.pop_front();
            gb = obsQ.pop_front(); go = obsOwnerQ.pop_front();
            checks++;
            if (gb !== eb || go !== eo) begin
                fails++;
                $display("[TB] FAIL timeout_byte: got %h/owner %0d, required %h/owner %0d", gb, go, eb, eo);
            end
        end
        // Reset lands while the audio byte sits in WAIT_DONE with the engine still busy.
        rst = 1'b1;
        tick();
        checks++;
        if ({spi_tx_start, spi_tx_data, owner, a_tx_busy, b_tx_busy, a_overrun, b_overrun, lock_err} !== 16'd0) begin
            fails++;
            $display("[TB] FAIL midbyte_reset: got start=%b data=%h owner=%0d busy=%b%b flags=%b%b%b, required all 0",
                     spi_tx_start, spi_tx_data, owner, a_tx_busy, b_tx_busy, a_overrun, b_overrun, lock_err);
        end
        rst = 1'b0; b_lock = 1'b0;
        repeat (20) tick();
        checks++;
        if (obsQ.size() != 0 || expQ.size() != 0 || owner !== 2'd0) begin
            fails++;
            $display("[TB] FAIL midbyte_quiet: got %0d extra strobes %0d missing owner=%0d, required 0 0 0",
                     obsQ.size(), expQ.size(), owner);
        end
        checks++;
        if (timeouts != 0) begin
            fails++;
            $display("[TB] FAIL timeout_wait: got %0d expired waits, required 0", timeouts);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (dataLeak != 0 || strobeRun != 0) begin
            fails++;
            $display("[TB] FAIL strobe_shape: got %0d data leaks %0d long strobes, required 0 0", dataLeak, strobeRun);
        end
    endtask

    initial begin
        $display("[TB] starting spi_tx_arbiter bench");
        test_reset();
        test_same_cycle();
        test_locked_pair();
        test_lock_no_interleave();
        test_starvation();
        test_overrun();
        test_lock_timeout_and_reset();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter STARVE_LIMIT SHALL default to 4 and set the consecutive audio grants allowed while a config byte waits.
REQ-003 Parameter LOCK_TIMEOUT SHALL default to 1024 and set the idle clocks a held lock may last before forced release.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- a_tx_start  in  1  audio requester byte strobe, one-cycle pulse
- a_tx_data  in  8  audio byte, sampled with a_tx_start
- a_lock  in  1  audio holds the bus across bytes (frame atomicity)
- a_tx_busy  out  1  audio byte pending or in flight
- b_tx_start  in  1  config requester byte strobe, one-cycle pulse
- b_tx_data  in  8  config byte, sampled with b_tx_start
- b_lock  in  1  config holds the bus across bytes
- b_tx_busy  out  1  config byte pending or in flight
- spi_tx_start  out  1  one-cycle strobe to the SPI byte engine
- spi_tx_data  out  8  byte to the SPI byte engine
- spi_tx_busy  in  1  engine busy; rises the cycle after spi_tx_start
- owner  out  2  0 none, 1 audio, 2 config
- a_overrun, b_overrun, lock_err  out  1  sticky error flags

Function
REQ-005 Each requester SHALL have a one-byte slot; a start captures the data and sets the slot's pending flag on the next edge.
REQ-006 x_tx_busy SHALL be high from the cycle after x_tx_start until the engine drops busy for that byte.
REQ-007 A start while the same slot is pending SHALL be dropped and SHALL set x_overrun.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-009 IDLE: if any slot is eligible, the FSM SHALL select the winner, latch owner, and go to ISSUE.
REQ-010 ISSUE: spi_tx_start SHALL be 1 for exactly one cycle, spi_tx_data SHALL hold the winner's byte, and the FSM SHALL go to WAIT_ACK.
REQ-011 WAIT_ACK SHALL go to WAIT_DONE when spi_tx_busy=1, and SHALL treat busy=0 as a completed byte.
REQ-012 WAIT_DONE SHALL, when spi_tx_busy=0, clear the winner's pending flag and return to IDLE.
REQ-013 A slot SHALL be eligible when pending, and not blocked by the other requester holding its lock while it is owner.
REQ-014 Priority SHALL favour audio, except that config SHALL win when its pending count of audio grants equals STARVE_LIMIT.
REQ-015 The starve count SHALL increment on each audio grant while config is pending, and SHALL clear on a config grant or when config is not pending.
REQ-016 When both slots become pending in the same cycle with neither locked, audio SHALL win.
REQ-017 owner SHALL stay at the last winner while its lock is high, and SHALL drop to 0 in IDLE when that lock is low.
REQ-018 The lock timeout counter SHALL count IDLE cycles with the owner locked and no pending byte from the owner.
REQ-019 At LOCK_TIMEOUT the lock SHALL be forcibly released (owner=0), lock_err SHALL set, and the lock SHALL stay ignored until its input falls.
REQ-020 spi_tx_data SHALL be 0 whenever spi_tx_start is 0.

Reset
REQ-021 Reset SHALL force: state IDLE, both pending flags 0, owner 0, spi_tx_start 0, spi_tx_data 0, busy outputs 0, counters 0, all sticky flags 0.
REQ-022 Reset mid-byte SHALL abandon the byte with no further strobe, and SHALL not wait for spi_tx_busy.
REQ-023 A start asserted in the reset cycle SHALL be ignored.

Structure
REQ-024 A shared package vox_pkg SHALL hold the owner encoding, the FSM state encoding, and the STARVE_LIMIT/LOCK_TIMEOUT defaults.
REQ-025 The per-requester slot (data register, pending flag, overrun detect) SHALL be a sub-module spi_req_slot, instantiated twice.

Verification
REQ-026 Single audio pair 0xCA, 0xFE with a_lock=1 and an engine busy of 8 cycles -> two strobes in order, a_tx_busy never low between them, owner=1 throughout.
REQ-027 Config 0x55 pending during a locked audio frame -> 0x55 issued only after a_lock falls, with no interleave inside the frame.
REQ-028 Audio unlocked and continuously pending, config pending -> config granted after exactly 4 audio bytes.
REQ-029 Same-cycle a_tx_start=0x11 and b_tx_start=0x22 -> 0x11 issued first, then 0x22.
REQ-030 Second a_tx_start while a_tx_busy=1 -> a_overrun=1 and the original byte transmitted unchanged.
REQ-031 b_lock held 1024 idle cycles -> lock_err=1 and a pending audio byte issued the next cycle; reset asserted during WAIT_DONE -> all outputs 0 the next cycle.
